coo_aggregate: RTL and testbench

COO_AGGREGATE -- requirements
Module: coo_aggregate

---
 rtl/coo_aggregate_pkg.sv | 18 +
 rtl/sat_row_adder.sv | 35 +++
 rtl/coo_aggregate.sv | 162 ++++++++++++++++
 tb/tb_coo_aggregate.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coo_aggregate_pkg.sv
// Shared types and default sizing for the COO graph aggregation engine.
package coo_aggregate_pkg;

    localparam int unsigned DEF_N_NODES   = 6;
    localparam int unsigned DEF_N_FEAT    = 3;
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_MAX_EDGES = 8;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StEdge,
        StRow,
        StAcc,
        StDone
    } agg_state_e;

endpackage

// File: rtl/sat_row_adder.sv
// Element-wise signed addition of two packed feature rows, each element clamped to DATA_W bits.
module sat_row_adder
    import coo_aggregate_pkg::*;
#(
    parameter int unsigned N_FEAT = DEF_N_FEAT,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [N_FEAT*DATA_W-1:0] i_a,
    input  logic [N_FEAT*DATA_W-1:0] i_b,
    output logic [N_FEAT*DATA_W-1:0] o_sum,
    output logic                     o_sat
);

    localparam logic [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W - 1){1'b0}}};

    logic [N_FEAT-1:0] w_clamp;

    for (genvar f = 0; f < N_FEAT; f++) begin : g_elem
        logic [DATA_W:0] w_a;
        logic [DATA_W:0] w_b;
        logic [DATA_W:0] w_wide;

        assign w_a    = {i_a[(f + 1) * DATA_W - 1], i_a[f * DATA_W +: DATA_W]};
        assign w_b    = {i_b[(f + 1) * DATA_W - 1], i_b[f * DATA_W +: DATA_W]};
        assign w_wide = w_a + w_b;
        // Overflow shows up as the two top bits of the sign-extended sum disagreeing.
        assign w_clamp[f] = w_wide[DATA_W] != w_wide[DATA_W - 1];
        assign o_sum[f * DATA_W +: DATA_W] = !w_clamp[f]     ? w_wide[DATA_W - 1:0] :
                                             w_wide[DATA_W] ? MinVal : MaxVal;
    end

    assign o_sat = |w_clamp;

endmodule

// File: rtl/coo_aggregate.sv
// Walks a COO edge list and accumulates source feature rows into destination rows with saturation.
module coo_aggregate
    import coo_aggregate_pkg::*;
#(
    parameter int unsigned N_NODES   = DEF_N_NODES,
    parameter int unsigned N_FEAT    = DEF_N_FEAT,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_EDGES = DEF_MAX_EDGES,
    localparam int unsigned EDGE_AW  = $clog2(MAX_EDGES),
    localparam int unsigned NODE_W   = $clog2(N_NODES),
    localparam int unsigned ROW_W    = N_FEAT * DATA_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [EDGE_AW:0]   i_num_edges,
    output logic [EDGE_AW-1:0] o_coo_addr,
    input  logic [NODE_W-1:0]  i_coo_src,
    input  logic [NODE_W-1:0]  i_coo_dst,
    output logic [NODE_W-1:0]  o_fm_row_addr,
    input  logic [ROW_W-1:0]   i_fm_row_data,
    input  logic [NODE_W-1:0]  i_rd_row,
    output logic [ROW_W-1:0]   o_rd_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_sat_flag,
    output logic               o_idx_err
);

    localparam int unsigned CNT_W = EDGE_AW + 1;

    agg_state_e         r_state;
    logic [CNT_W-1:0]   r_num_edges;
    logic [CNT_W-1:0]   r_edge_idx;
    logic [EDGE_AW-1:0] r_coo_addr;
    logic [NODE_W-1:0]  r_fm_row_addr;
    logic [NODE_W-1:0]  r_dst;
    logic               r_edge_ok;
    logic               r_busy;
    logic               r_done;
    logic               r_sat_flag;
    logic               r_idx_err;
    logic [ROW_W-1:0]   r_acc [N_NODES];

    logic [CNT_W-1:0]   w_idx_next;
    logic [CNT_W-1:0]   w_num_clamped;
    logic               w_src_ok;
    logic               w_dst_ok;
    logic [ROW_W-1:0]   w_acc_row;
    logic [ROW_W-1:0]   w_sum_row;
    logic               w_sum_sat;

    assign w_idx_next    = r_edge_idx + CNT_W'(1);
    assign w_num_clamped = (32'(i_num_edges) > MAX_EDGES) ? CNT_W'(MAX_EDGES) : i_num_edges;
    assign w_src_ok      = 32'(i_coo_src) < N_NODES;
    assign w_dst_ok      = 32'(i_coo_dst) < N_NODES;

    always_comb begin
        w_acc_row = '0;
        o_rd_data = '0;
        for (int n = 0; n < N_NODES; n++) begin
            if (NODE_W'(n) == r_dst) w_acc_row = r_acc[n];
            if (NODE_W'(n) == i_rd_row) o_rd_data = r_acc[n];
        end
    end

    sat_row_adder #(
        .N_FEAT (N_FEAT),
        .DATA_W (DATA_W)
    ) u_adder (
        .i_a   (w_acc_row),
        .i_b   (i_fm_row_data),
        .o_sum (w_sum_row),
        .o_sat (w_sum_sat)
    );

    // Addresses are live during their own state so the one-cycle read latency lines up with the
    // following state; otherwise they hold the last value presented.
    assign o_coo_addr    = (r_state == StEdge) ? r_edge_idx[EDGE_AW-1:0] : r_coo_addr;
    assign o_fm_row_addr = (r_state == StRow) ? i_coo_src : r_fm_row_addr;

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_sat_flag = r_sat_flag;
    assign o_idx_err  = r_idx_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_num_edges   <= '0;
            r_edge_idx    <= '0;
            r_coo_addr    <= '0;
            r_fm_row_addr <= '0;
            r_dst         <= '0;
            r_edge_ok     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_sat_flag    <= 1'b0;
            r_idx_err     <= 1'b0;
            for (int n = 0; n < N_NODES; n++) r_acc[n] <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_num_edges <= w_num_clamped;
                        r_edge_idx  <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= StClear;
                    end
                end
                StClear: begin
                    for (int n = 0; n < N_NODES; n++) r_acc[n] <= '0;
                    r_sat_flag <= 1'b0;
                    r_idx_err  <= 1'b0;
                    if (r_num_edges == '0) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_state <= StEdge;
                    end
                end
                StEdge: begin
                    r_coo_addr <= r_edge_idx[EDGE_AW-1:0];
                    r_state    <= StRow;
                end
                StRow: begin
                    r_dst         <= i_coo_dst;
                    r_fm_row_addr <= i_coo_src;
                    r_edge_ok     <= w_src_ok && w_dst_ok;
                    r_state       <= StAcc;
                end
                StAcc: begin
                    if (r_edge_ok) begin
                        for (int n = 0; n < N_NODES; n++) begin
                            if (NODE_W'(n) == r_dst) r_acc[n] <= w_sum_row;
                        end
                        if (w_sum_sat) r_sat_flag <= 1'b1;
                    end else begin
                        r_idx_err <= 1'b1;
                    end
                    r_edge_idx <= w_idx_next;
                    if (w_idx_next < r_num_edges) begin
                        r_state <= StEdge;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coo_aggregate.sv
// Randomised and directed checks of coo_aggregate against an edge-list reference model.
`timescale 1ns/1ps
module tb_coo_aggregate;

    localparam int N_NODES   = 6;
    localparam int N_FEAT    = 3;
    localparam int DATA_W    = 16;
    localparam int MAX_EDGES = 8;
    localparam int EDGE_AW   = $clog2(MAX_EDGES);
    localparam int NODE_W    = $clog2(N_NODES);
    localparam int ROW_W     = N_FEAT * DATA_W;
    localparam int CW        = EDGE_AW + 1;
    localparam int SMAX      = 32767;
    localparam int SMIN      = -32768;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [EDGE_AW:0]   num_edges;
    logic [EDGE_AW-1:0] coo_addr;
    logic [NODE_W-1:0]  coo_src_q;
    logic [NODE_W-1:0]  coo_dst_q;
    logic [NODE_W-1:0]  fm_row_addr;
    logic [ROW_W-1:0]   fm_q;
    logic [NODE_W-1:0]  rd_row;
    logic [ROW_W-1:0]   rd_data;
    logic               busy, done, sat_flag, idx_err;

    int src_mem [MAX_EDGES];
    int dst_mem [MAX_EDGES];
    int fm_val  [8][N_FEAT];
    int exp_acc [N_NODES][N_FEAT];
    int got_acc [N_NODES][N_FEAT];
    bit exp_sat, exp_err;
    int exp_lat;
    int n_checks = 0;
    int n_pass   = 0;

    coo_aggregate #(
        .N_NODES   (N_NODES),
        .N_FEAT    (N_FEAT),
        .DATA_W    (DATA_W),
        .MAX_EDGES (MAX_EDGES)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_num_edges   (num_edges),
        .o_coo_addr    (coo_addr),
        .i_coo_src     (coo_src_q),
        .i_coo_dst     (coo_dst_q),
        .o_fm_row_addr (fm_row_addr),
        .i_fm_row_data (fm_q),
        .i_rd_row      (rd_row),
        .o_rd_data     (rd_data),
        .o_busy        (busy),
        .o_done        (done),
        .o_sat_flag    (sat_flag),
        .o_idx_err     (idx_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data appears one cycle after the address.
    always @(posedge clk) begin
        coo_src_q <= NODE_W'(src_mem[coo_addr]);
        coo_dst_q <= NODE_W'(dst_mem[coo_addr]);
        for (int f = 0; f < N_FEAT; f++) fm_q[f*DATA_W +: DATA_W] <= DATA_W'(fm_val[fm_row_addr][f]);
    end

    function automatic void model(input int n);
        int m, v;
        m = (n > MAX_EDGES) ? MAX_EDGES : n;
        exp_sat = 0;
        exp_err = 0;
        foreach (exp_acc[r, f]) exp_acc[r][f] = 0;
        for (int e = 0; e < m; e++) begin
            if (src_mem[e] >= N_NODES || dst_mem[e] >= N_NODES) begin
                exp_err = 1;
            end else begin
                for (int f = 0; f < N_FEAT; f++) begin
                    v = exp_acc[dst_mem[e]][f] + fm_val[src_mem[e]][f];
                    if (v > SMAX) begin v = SMAX; exp_sat = 1; end
                    if (v < SMIN) begin v = SMIN; exp_sat = 1; end
                    exp_acc[dst_mem[e]][f] = v;
                end
            end
        end
        exp_lat = 3 * m + 2;
    endfunction

    task automatic read_all();
        for (int r = 0; r < N_NODES; r++) begin
            @(negedge clk);
            rd_row = NODE_W'(r);
            #1;
            for (int f = 0; f < N_FEAT; f++) got_acc[r][f] = int'($signed(rd_data[f*DATA_W +: DATA_W]));
        end
    endtask

    // Pulse start at cycle 0, report first cycle done is seen and how many done pulses occur.
    task automatic run_op(input int n, input bit extra_start, output int lat, output int ndone);
        lat = -1;
        ndone = 0;
        @(negedge clk);
        num_edges = CW'(n);
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = extra_start && (c == 3);
            if (extra_start && c == 3) num_edges = CW'(1);
            if (done) begin
                ndone++;
                if (lat < 0) lat = c;
            end
            if (lat >= 0 && c >= lat + 4) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_edges = '0; rd_row = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("FAIL reset_sat: got %b want 0", sat_flag); else n_pass++;
        n_checks++; if (idx_err !== 1'b0) $display("FAIL reset_idx_err: got %b want 0", idx_err); else n_pass++;
        n_checks++; if (coo_addr !== '0) $display("FAIL reset_coo_addr: got %0d want 0", coo_addr); else n_pass++;
        n_checks++; if (fm_row_addr !== '0) $display("FAIL reset_fm_addr: got %0d want 0", fm_row_addr); else n_pass++;
        read_all();
        foreach (got_acc[r, f]) begin
            n_checks++;
            if (got_acc[r][f] !== 0) $display("FAIL reset_acc[%0d][%0d]: got %0d want 0", r, f, got_acc[r][f]);
            else n_pass++;
        end
    endtask

    task automatic test_directed();
        int lat, nd;
        foreach (fm_val[r, f]) fm_val[r][f] = 0;
        fm_val[0] = '{1, 2, 3};
        fm_val[2] = '{10, 20, 30};
        fm_val[3] = '{-5, 0, 5};
        src_mem = '{0, 2, 3, 0, 0, 0, 0, 0};
        dst_mem = '{1, 1, 4, 0, 0, 0, 0, 0};
        model(3);
        run_op(3, 1'b0, lat, nd);
        n_checks++; if (lat !== 11) $display("FAIL directed_latency: got %0d want 11", lat); else n_pass++;
        n_checks++; if (nd !== 1) $display("FAIL directed_done_count: got %0d want 1", nd); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL directed_busy_after: got %b want 0", busy); else n_pass++;
        read_all();
        n_checks++;
        if (got_acc[1][0] !== 11 || got_acc[1][1] !== 22 || got_acc[1][2] !== 33)
            $display("FAIL directed_acc1: got %0d,%0d,%0d want 11,22,33", got_acc[1][0], got_acc[1][1], got_acc[1][2]);
        else n_pass++;
        foreach (got_acc[r, f]) begin
            n_checks++;
            if (got_acc[r][f] !== exp_acc[r][f])
                $display("FAIL directed_acc[%0d][%0d]: got %0d want %0d", r, f, got_acc[r][f], exp_acc[r][f]);
            else n_pass++;
        end
    endtask

    task automatic test_zero_edges();
        int lat, nd;
        model(0);
        run_op(0, 1'b0, lat, nd);
        n_checks++; if (lat !== 2) $display("FAIL zero_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (idx_err !== 1'b0) $display("FAIL zero_idx_err: got %b want 0", idx_err); else n_pass++;
        read_all();
        foreach (got_acc[r, f]) begin
            n_checks++;
            if (got_acc[r][f] !== 0) $display("FAIL zero_acc[%0d][%0d]: got %0d want 0", r, f, got_acc[r][f]);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int lat, nd;
        fm_val[0] = '{20000, -20000, 1};
        src_mem[0] = 0; dst_mem[0] = 0;
        src_mem[1] = 0; dst_mem[1] = 0;
        model(2);
        run_op(2, 1'b0, lat, nd);
        n_checks++; if (sat_flag !== 1'b1) $display("FAIL sat_flag: got %b want 1", sat_flag); else n_pass++;
        read_all();
        n_checks++;
        if (got_acc[0][0] !== SMAX || got_acc[0][1] !== SMIN || got_acc[0][2] !== 2)
            $display("FAIL sat_acc0: got %0d,%0d,%0d want 32767,-32768,2", got_acc[0][0], got_acc[0][1], got_acc[0][2]);
        else n_pass++;
    endtask

    task automatic test_bad_index();
        int lat, nd;
        fm_val[0] = '{1, 2, 3};
        fm_val[2] = '{7, 8, 9};
        fm_val[7] = '{100, 100, 100};
        src_mem = '{0, 7, 2, 0, 0, 0, 0, 0};
        dst_mem = '{2, 2, 3, 0, 0, 0, 0, 0};
        model(3);
        run_op(3, 1'b0, lat, nd);
        n_checks++; if (lat !== 11) $display("FAIL badidx_latency: got %0d want 11", lat); else n_pass++;
        n_checks++; if (idx_err !== 1'b1) $display("FAIL badidx_flag: got %b want 1", idx_err); else n_pass++;
        read_all();
        foreach (got_acc[r, f]) begin
            n_checks++;
            if (got_acc[r][f] !== exp_acc[r][f])
                $display("FAIL badidx_acc[%0d][%0d]: got %0d want %0d", r, f, got_acc[r][f], exp_acc[r][f]);
            else n_pass++;
        end
    endtask

    task automatic randomize_tables(input bit wide);
        for (int e = 0; e < MAX_EDGES; e++) begin
            src_mem[e] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            dst_mem[e] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
        end
        foreach (fm_val[r, f])
            fm_val[r][f] = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 200)) - 100;
    endtask

    task automatic test_random();
        int lat, nd, n;
        for (int it = 0; it < 12; it++) begin
            randomize_tables(it[0]);
            n = int'($urandom_range(0, 10));
            model(n);
            run_op(n, 1'b0, lat, nd);
            n_checks++; if (lat !== exp_lat) $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, exp_lat); else n_pass++;
            n_checks++; if (nd !== 1) $display("FAIL rand%0d_done_count: got %0d want 1", it, nd); else n_pass++;
            n_checks++; if (sat_flag !== exp_sat) $display("FAIL rand%0d_sat: got %b want %b", it, sat_flag, exp_sat); else n_pass++;
            n_checks++; if (idx_err !== exp_err) $display("FAIL rand%0d_idx_err: got %b want %b", it, idx_err, exp_err); else n_pass++;
            read_all();
            foreach (got_acc[r, f]) begin
                n_checks++;
                if (got_acc[r][f] !== exp_acc[r][f])
                    $display("FAIL rand%0d_acc[%0d][%0d]: got %0d want %0d", it, r, f, got_acc[r][f], exp_acc[r][f]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, nd;
        randomize_tables(1'b0);
        @(negedge clk);
        num_edges = CW'(8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) nd++;
            @(negedge clk);
        end
        n_checks++; if (nd !== 0) $display("FAIL midrst_stray_done: got %0d want 0", nd); else n_pass++;
        read_all();
        n_checks++; if (got_acc[dst_mem[0] % N_NODES][0] !== 0) $display("FAIL midrst_acc_cleared: got %0d want 0", got_acc[dst_mem[0] % N_NODES][0]); else n_pass++;
        model(8);
        run_op(8, 1'b0, lat, nd);
        n_checks++; if (lat !== 26) $display("FAIL midrst_rerun_latency: got %0d want 26", lat); else n_pass++;
        read_all();
        foreach (got_acc[r, f]) begin
            n_checks++;
            if (got_acc[r][f] !== exp_acc[r][f])
                $display("FAIL midrst_acc[%0d][%0d]: got %0d want %0d", r, f, got_acc[r][f], exp_acc[r][f]);
            else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        int lat, nd;
        randomize_tables(1'b0);
        model(5);
        run_op(5, 1'b1, lat, nd);
        n_checks++; if (lat !== 17) $display("FAIL busy_start_latency: got %0d want 17", lat); else n_pass++;
        n_checks++; if (nd !== 1) $display("FAIL busy_start_done_count: got %0d want 1", nd); else n_pass++;
        read_all();
        foreach (got_acc[r, f]) begin
            n_checks++;
            if (got_acc[r][f] !== exp_acc[r][f])
                $display("FAIL busy_start_acc[%0d][%0d]: got %0d want %0d", r, f, got_acc[r][f], exp_acc[r][f]);
            else n_pass++;
        end
    endtask

    initial begin
        foreach (src_mem[e]) begin src_mem[e] = 0; dst_mem[e] = 0; end
        foreach (fm_val[r, f]) fm_val[r][f] = 0;
        test_reset();
        test_directed();
        test_zero_edges();
        test_saturation();
        test_bad_index();
        test_random();
        test_reset_mid_run();
        test_start_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
